// File: rtl/period_meter.sv
// period_meter: counts Fin cycles between two consecutive rising edges of an asynchronous input
// and presents the result through a valid/ack handshake.
`timescale 1ns/100ps
module period_meter #(
    parameter int CW = 24
) (
    input  logic          fin_i,
    input  logic          reset_i,
    input  logic          fmeas_i,
    input  logic          start_i,
    input  logic          ack_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);
    localparam logic [CW-1:0] MAX = '1;
    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q, count_q;
    logic          busy_q, valid_q, ovf_q, s1_q, s2_q, dly_q;
    logic          edge_w;
    // Synchronizer and delay flop share the same latency for both edges, so it cancels.
    assign edge_w  = s2_q & ~dly_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    always_ff @(posedge fin_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            s1_q  <= fmeas_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= ARM;
                    busy_q  <= 1'b1;
                end
                ARM: if (edge_w) begin
                    cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
                    state_q <= MEAS;
                end
                // Saturation at MAX without an edge reports a timeout with Count = MAX.
                MEAS: if (edge_w || cnt_q == MAX) begin
                    count_q <= cnt_q;
                    ovf_q   <= ~edge_w;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: if (ack_i) begin
                    valid_q <= 1'b0;
                    busy_q  <= start_i;
                    state_q <= start_i ? ARM : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed measurements checked against literals, plus an edge-timestamp
// reference model compared against every DUT output on every cycle.
`timescale 1ns/100ps
module tb_period_meter;
    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;
    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, ack = 1'b0, async_f = 1'b0;
    logic          busy, valid, ovf, fmeas;
    logic [CW-1:0] count;
    logic [15:0]   dcnt = '0;
    int            fsel = 5, mode = 0;
    int            n_assert = 0, n_fail = 0, n_vr = 0, cyc = 0;
    logic          m_busy = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
    int            m_count = 0, m_first = -1;

    assign fmeas = mode == 0 ? dcnt[fsel-1] : (mode == 1 ? async_f : 1'b0);

    period_meter #(.CW(CW)) dut (
        .fin_i(clk), .reset_i(reset), .fmeas_i(fmeas), .start_i(start), .ack_i(ack),
        .busy_o(busy), .valid_o(valid), .count_o(count), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    // Divider source: Fin / 2^fsel, stepped away from the sampling edge.
    initial forever begin
        @(negedge clk);
        dcnt = dcnt + 1'b1;
    end

    // Asynchronous 327 ns source, offset so it never toggles on a clock edge.
    initial begin
        #163.8;
        forever begin
            async_f = ~async_f;
            #163.5;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the result is the distance in cycles between the first rising edge seen
    // after arming and the next one, saturating at MAX; everything observed 2 cycles later.
    initial begin
        logic       er, prev_f;
        logic [1:0] rise_h;
        prev_f = 1'b0;
        rise_h = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                prev_f  = 1'b0;
                rise_h  = '0;
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_ovf   = 1'b0;
                m_count = 0;
                m_first = -1;
            end else begin
                er     = rise_h[1];
                rise_h = {rise_h[0], fmeas & ~prev_f};
                prev_f = fmeas;
                if (m_busy && m_first < 0) begin
                    if (er) m_first = cyc;
                end else if (m_busy) begin
                    if (er || cyc - m_first == MAX) begin
                        m_count = cyc - m_first;
                        m_ovf   = !er;
                        m_busy  = 1'b0;
                        m_valid = 1'b1;
                        m_first = -1;
                    end
                end else if (m_valid) begin
                    if (ack) begin
                        m_valid = 1'b0;
                        m_busy  = start;
                    end
                end else if (start) begin
                    m_busy = 1'b1;
                end
            end
            cyc++;
        end
    end

    initial begin
        logic pv;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                check("model busy", busy, m_busy);
                check("model valid", valid, m_valid);
                check("model count", count, m_count);
                check("model ovf", ovf, m_ovf);
            end
            if (valid && !pv) n_vr++;
            pv = valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_ack(input logic with_start);
        ack   = 1'b1;
        start = with_start;
        tick();
        ack   = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int lim, input string name);
        int i = 0;
        while (!valid && i < lim) begin
            tick();
            i++;
        end
        check({name, " valid"}, valid, 1);
    endtask

    task automatic wait_meas(input int lim, input string name);
        int i = 0;
        while (m_first < 0 && i < lim) begin
            tick();
            i++;
        end
        check({name, " meas"}, m_first >= 0, 1);
    endtask

    initial begin
        tick(3);
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset count", count, 0);
        check("reset ovf", ovf, 0);
        reset = 1'b0;
        tick(5);
        pulse_start();
        check("t1 busy", busy, 1);
        wait_valid(300, "t1");
        check("t1 count", count, 32);
        check("t1 ovf", ovf, 0);
        do_ack(1'b0);
        check("t1 valid cleared", valid, 0);
        check("t1 busy idle", busy, 0);
        fsel = 1;
        tick(10);
        pulse_start();
        wait_valid(50, "t2a");
        check("t2a count", count, 2);
        check("t2a ovf", ovf, 0);
        do_ack(1'b1);
        check("t2 back-to-back busy", busy, 1);
        check("t2 back-to-back valid", valid, 0);
        wait_valid(50, "t2b");
        check("t2b count", count, 2);
        do_ack(1'b0);
        fsel = 12;
        tick(10);
        pulse_start();
        wait_valid(5000, "t3a");
        check("t3a count", count, 255);
        check("t3a ovf", ovf, 1);
        fsel = 5;
        tick(10);
        check("t3 valid held", valid, 1);
        do_ack(1'b1);
        wait_valid(300, "t3b");
        check("t3b count", count, 32);
        check("t3b ovf", ovf, 0);
        do_ack(1'b0);
        mode = 1;
        tick(10);
        repeat (20) begin
            pulse_start();
            wait_valid(300, "t4");
            check("t4 count range", count == 8'd32 || count == 8'd33, 1);
            check("t4 ovf", ovf, 0);
            do_ack(1'b0);
            tick(3);
        end
        mode = 0;
        fsel = 5;
        tick(10);
        pulse_start();
        wait_meas(100, "t5");
        tick(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 reset busy", busy, 0);
        check("t5 reset valid", valid, 0);
        check("t5 reset count", count, 0);
        tick(100);
        check("t5 discarded", valid, 0);
        pulse_start();
        wait_valid(300, "t5");
        check("t5 count", count, 32);
        do_ack(1'b0);
        tick(5);
        pulse_start();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t6 ack in arm ignored", busy, 1);
        wait_meas(100, "t6");
        tick(5);
        pulse_start();
        check("t6 start in meas busy", busy, 1);
        wait_valid(300, "t6");
        check("t6 count", count, 32);
        do_ack(1'b0);
        tick(100);
        check("t6 no extra valid", valid, 0);
        check("valid per start", n_vr, 27);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
